// File: rtl/vga_timing_pkg.sv
// Raster timing defaults shared by the Pong VGA generator and the receive-side decoder,
// plus the decoder's lock FSM state encoding.
package vga_timing_pkg;

    localparam int unsigned HTotal     = 768;
    localparam int unsigned HActive    = 640;
    localparam int unsigned HSyncStart = 720;
    localparam int unsigned VTotal     = 512;
    localparam int unsigned VActive    = 480;
    localparam int unsigned VSyncStart = 500;

    typedef enum logic [1:0] {
        StSearch,
        StAcquire,
        StLocked
    } rx_state_e;

endpackage

// File: rtl/vga_sync_edge.sv
// One sync wire: polarity normalise, pixel-rate sample register and inactive->active detect.
module vga_sync_edge #(
    parameter bit SyncActLow = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pix_en_i,
    input  logic sync_i,
    output logic edge_o
);

    logic sync_act;
    logic sync_q;

    assign sync_act = SyncActLow ? ~sync_i : sync_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
        end else if (pix_en_i) begin
            sync_q <= sync_act;
        end
    end

    // The edge belongs to the sample being registered on this strobe.
    assign edge_o = pix_en_i & sync_act & ~sync_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA monitor: recovers x/y from sync edges, locks to the raster and
// counts sync edges that disagree with the recovered position.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL      = HTotal,
    parameter int unsigned H_ACTIVE     = HActive,
    parameter int unsigned H_SYNC_START = HSyncStart,
    parameter int unsigned V_TOTAL      = VTotal,
    parameter int unsigned V_ACTIVE     = VActive,
    parameter int unsigned V_SYNC_START = VSyncStart,
    parameter bit          SYNC_ACT_LOW = 1'b1,
    parameter int unsigned LOCK_FRAMES  = 2,
    parameter int unsigned MISS_LIMIT   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    input  logic       vga_h_sync,
    input  logic       vga_v_sync,
    input  logic [2:0] vga_rgb,
    output logic [9:0] rx_x,
    output logic [8:0] rx_y,
    output logic [2:0] rx_rgb,
    output logic       rx_de,
    output logic       rx_valid,
    output logic       frame_start,
    output logic       locked,
    output logic [7:0] err_cnt
);

    localparam logic [9:0]  XLast   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  XSync   = 10'(H_SYNC_START);
    localparam logic [9:0]  XAct    = 10'(H_ACTIVE);
    localparam logic [8:0]  YLast   = 9'(V_TOTAL - 1);
    localparam logic [8:0]  YSync   = 9'(V_SYNC_START);
    localparam logic [8:0]  YAct    = 9'(V_ACTIVE);
    localparam logic [10:0] ToLast  = 11'(2 * H_TOTAL - 1);
    localparam logic [3:0]  GoodLim = 4'(LOCK_FRAMES);
    localparam logic [3:0]  MissLim = 4'(MISS_LIMIT);

    logic hs_edge, vs_edge;

    vga_sync_edge #(.SyncActLow(SYNC_ACT_LOW)) u_hs_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_en_i (pix_en),
        .sync_i   (vga_h_sync),
        .edge_o   (hs_edge)
    );

    vga_sync_edge #(.SyncActLow(SYNC_ACT_LOW)) u_vs_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_en_i (pix_en),
        .sync_i   (vga_v_sync),
        .edge_o   (vs_edge)
    );

    logic [9:0]  x_q, x_d, x_inc;
    logic [8:0]  y_q, y_d, y_inc;
    logic        x_wrap, hs_mis, vs_mis, mis, tmo, err_inc, lock_d;
    rx_state_e   state_q, state_d;
    logic [3:0]  good_q, good_d, miss_q, miss_d;
    logic [10:0] to_q, to_d;
    logic [7:0]  err_q;
    logic [2:0]  rgb_q;
    logic        locked_q, de_q, fs_q, valid_q;

    // Free-running position, overridden whenever a sync edge disagrees with it.
    always_comb begin
        x_wrap = (x_q == XLast);
        x_inc  = x_wrap ? 10'd0 : x_q + 10'd1;
        y_inc  = y_q;
        if (x_wrap) begin
            y_inc = (y_q == YLast) ? 9'd0 : y_q + 9'd1;
        end
        hs_mis = hs_edge && (x_inc != XSync);
        vs_mis = vs_edge && ((x_inc != 10'd0) || (y_inc != YSync));
        x_d    = hs_mis ? XSync : x_inc;
        y_d    = vs_mis ? YSync : y_inc;
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        miss_d  = miss_q;
        err_inc = 1'b0;
        mis     = hs_mis | vs_mis;
        tmo     = (state_q != StSearch) && pix_en && !hs_edge && (to_q == ToLast);
        unique case (state_q)
            StSearch: begin
                if (vs_edge) begin
                    state_d = StAcquire;
                    good_d  = 4'd0;
                    miss_d  = 4'd0;
                end
            end
            StAcquire: begin
                err_inc = mis | tmo;
                if (mis || tmo) begin
                    state_d = StSearch;
                end else if (pix_en && x_wrap && (y_q == YLast)) begin
                    good_d = good_q + 4'd1;
                    if (good_d == GoodLim) begin
                        state_d = StLocked;
                    end
                end
            end
            StLocked: begin
                err_inc = mis | tmo;
                if (tmo) begin
                    state_d = StSearch;
                end else if (mis) begin
                    miss_d = miss_q + 4'd1;
                    if (miss_d == MissLim) begin
                        state_d = StSearch;
                    end
                end else if (hs_edge || vs_edge) begin
                    miss_d = 4'd0;
                end
            end
            default: state_d = StSearch;
        endcase
        if ((state_d == StSearch) || hs_edge) begin
            to_d = 11'd0;
        end else if (pix_en) begin
            to_d = to_q + 11'd1;
        end else begin
            to_d = to_q;
        end
        lock_d = (state_d == StLocked);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StSearch;
            good_q   <= 4'd0;
            miss_q   <= 4'd0;
            to_q     <= 11'd0;
            err_q    <= 8'd0;
            locked_q <= 1'b0;
        end else if (pix_en) begin
            state_q  <= state_d;
            good_q   <= good_d;
            miss_q   <= miss_d;
            to_q     <= to_d;
            locked_q <= lock_d;
            if (err_inc && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= 10'd0;
            y_q     <= 9'd0;
            rgb_q   <= 3'd0;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= pix_en;
            fs_q    <= 1'b0;
            if (pix_en) begin
                x_q   <= x_d;
                y_q   <= y_d;
                rgb_q <= vga_rgb;
                de_q  <= lock_d && (x_d < XAct) && (y_d < YAct);
                fs_q  <= lock_d && (x_d == 10'd0) && (y_d == 9'd0);
            end
        end
    end

    assign rx_x        = x_q;
    assign rx_y        = y_q;
    assign rx_rgb      = rgb_q;
    assign rx_de       = de_q;
    assign rx_valid    = valid_q;
    assign frame_start = fs_q;
    assign locked      = locked_q;
    assign err_cnt     = err_q;

endmodule
